// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback unit.
// Holds register/data widths, load funct3 codes and the FIFO entry bundle.
package writeback_unit_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: selects and extends a byte/halfword of a memory word.
// Purely combinational; unknown funct3 codes fall back to a full word.
module load_formatter
    import writeback_unit_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes
    always_comb begin
        byte_sel = word[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane according to the load width/sign code
    always_comb begin
        data = word;
        unique case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: result FIFO draining one write per cycle into the regfile,
// plus a busy-register scoreboard that stalls WAW issues.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [REG_ADDR_W-1:0] res_rd,
    input  logic [XLEN-1:0]       res_data,
    input  logic                  res_load,
    input  logic [2:0]            res_funct3,
    input  logic [1:0]            res_addr_lo,
    output logic [XLEN-1:0]       addr_rd,
    output logic [XLEN-1:0]       data_rd,
    output logic                  write_enable,
    output logic [XLEN-1:0]       busy_mask
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [XLEN-1:0]       busy_q;
    logic [XLEN-1:0]       busy_next;
    logic [XLEN-1:0]       fmt_data;
    logic [XLEN-1:0]       push_data;
    wb_entry_t             head;
    logic                  nonempty;
    logic                  out_valid;
    logic                  push;
    logic                  pop;
    logic                  issue_fire;

    load_formatter u_fmt (
        .word    (res_data),
        .funct3  (res_funct3),
        .addr_lo (res_addr_lo),
        .data    (fmt_data)
    );

    // Handshakes and head-of-queue writeback outputs
    always_comb begin
        nonempty     = (count != '0);
        head         = fifo_q[rd_ptr];
        res_ready    = (count < FULL_CNT);
        issue_ready  = ~busy_q[issue_rd];
        issue_fire   = issue_valid & issue_ready;
        push         = res_valid & res_ready;
        pop          = nonempty;
        push_data    = res_load ? fmt_data : res_data;
        out_valid    = nonempty & ~reset;
        write_enable = out_valid & (head.rd != '0);
        addr_rd      = out_valid ? XLEN'(head.rd) : '0;
        data_rd      = out_valid ? head.data : '0;
        busy_mask    = busy_q;
    end

    // Scoreboard: clear on writeback, set on issue (never for x0)
    always_comb begin
        busy_next = busy_q;
        if (pop && head.rd != '0) begin
            busy_next[head.rd] = 1'b0;
        end
        if (issue_fire && issue_rd != '0) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    // FIFO pointers, occupancy and scoreboard state
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage holds already-formatted data; contents need no reset
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_q[wr_ptr] <= '{rd: res_rd, data: push_data};
        end
    end

endmodule
